taillight_seq: RTL and testbench

TAILLIGHT_SEQ -- requirements
Module: taillight_seq

---
 rtl/taillight_seq.sv | 141 ++++++++++++++
 tb/tb_taillight_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/taillight_seq.sv
// rtl/taillight_seq.sv - three-lamp sequential tail light controller
//
// Purpose: drives three tail-light lamps from a 2-bit brake/turn command.
//   00 off, 01 brake (all lit), 10 turn (inner-to-outer sweep),
//   11 brake+turn (steady all lit, or flashing when HAZARD_EN is defined).
//   Any command change restarts the prescaler and the sweep from the dark step.
//
// Ports:
//   clk    in   system clock, rising-edge active
//   rst_n  in   asynchronous active-low reset
//   mode   in   [1:0] light command
//   led1   out  inner lamp, 1 = lit (registered)
//   led2   out  middle lamp, 1 = lit (registered)
//   led3   out  outer lamp, 1 = lit (registered)
//
// Configuration macro: HAZARD_EN - when defined, mode 11 flashes all lamps
//   with a 50% duty cycle of TICK_DIV cycles per half period.

module taillight_seq #(
  parameter int TICK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  output logic       led1,
  output logic       led2,
  output logic       led3
);

  typedef enum logic [1:0] {
    SEQ0 = 2'd0,
    SEQ1 = 2'd1,
    SEQ2 = 2'd2,
    SEQ3 = 2'd3
  } seq_e;

  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);

  logic [1:0]  mode_q, mode_d;
  logic [23:0] count_q, count_d;
  seq_e        seq_q, seq_d;
  logic [2:0]  led_q, led_d;
  logic        mode_chg;
  logic        tick;

`ifdef HAZARD_EN
  logic        phase_q, phase_d;
`endif

  assign mode_chg = (mode != mode_q);
  assign tick     = (count_q == TICK_LAST);

  always_comb begin
    mode_d  = mode;
    count_d = count_q;
    seq_d   = seq_q;
`ifdef HAZARD_EN
    phase_d = phase_q;
`endif

    if (mode_chg) begin
      // A new command restarts everything; it also beats a coincident tick.
      count_d = '0;
      seq_d   = SEQ0;
`ifdef HAZARD_EN
      phase_d = 1'b1;
`endif
    end else begin
      count_d = tick ? '0 : count_q + 24'd1;

      if (mode_q != 2'b10) begin
        seq_d = SEQ0;
      end else if (tick) begin
        case (seq_q)
          SEQ0:    seq_d = SEQ1;
          SEQ1:    seq_d = SEQ2;
          SEQ2:    seq_d = SEQ3;
          default: seq_d = SEQ0;
        endcase
      end

`ifdef HAZARD_EN
      if (tick && (mode_q == 2'b11)) begin
        phase_d = ~phase_q;
      end
`endif
    end
  end

  // LEDs decode the already-registered command, giving a two-edge
  // command-to-lamp latency.
  always_comb begin
    led_d = 3'b000;
    case (mode_q)
      2'b00: led_d = 3'b000;
      2'b01: led_d = 3'b111;
      2'b10: begin
        case (seq_q)
          SEQ0:    led_d = 3'b000;
          SEQ1:    led_d = 3'b100;
          SEQ2:    led_d = 3'b110;
          default: led_d = 3'b111;
        endcase
      end
      default: begin
`ifdef HAZARD_EN
        led_d = {3{phase_q}};
`else
        led_d = 3'b111;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= 2'b00;
      count_q <= '0;
      seq_q   <= SEQ0;
      led_q   <= 3'b000;
    end else begin
      mode_q  <= mode_d;
      count_q <= count_d;
      seq_q   <= seq_d;
      led_q   <= led_d;
    end
  end

`ifdef HAZARD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b1;
    end else begin
      phase_q <= phase_d;
    end
  end
`endif

  assign {led1, led2, led3} = led_q;

endmodule

// File: tb/tb_taillight_seq.sv
// tb/tb_taillight_seq.sv - table-driven self-checking bench for taillight_seq

module tb_taillight_seq;

  localparam int TICK_DIV = 4;

`ifdef HAZARD_EN
  localparam logic [2:0] HZ_LAST = 3'b000;
`else
  localparam logic [2:0] HZ_LAST = 3'b111;
`endif

  typedef struct {
    logic [1:0] mode;
    logic [2:0] exp_led;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       led1, led2, led3;

  int n_cmp;
  int n_bad;

  vec_t vecs[$];

  taillight_seq #(.TICK_DIV(TICK_DIV)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mode (mode),
    .led1 (led1),
    .led2 (led2),
    .led3 (led3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic [1:0] m, input logic [2:0] e, input int n);
    vec_t v;
    v.mode    = m;
    v.exp_led = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [2:0] exp_led);
    logic [2:0] act;
    act = {led1, led2, led3};
    n_cmp++;
    if (act !== exp_led) begin
      n_bad++;
      $display("FAIL %s: leds=%b required=%b at t=%0t", name, act, exp_led, $time);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1;
    mode  = 2'b10;

    // Asynchronous reset with turn commanded, before any clock edge.
    #2 rst_n = 1'b0;
    #1 check("reset_async", 3'b000);
    step();
    check("reset_held", 3'b000);
    step();
    mode  = 2'b00;
    rst_n = 1'b1;

    // Idle after release, then brake held for 40 cycles.
    add(2'b00, 3'b000, 3);
    add(2'b01, 3'b000, 1);
    add(2'b01, 3'b111, 40);
    // Turn sweep, each step exactly 4 cycles, wrapping past SEQ3.
    add(2'b10, 3'b111, 1);
    add(2'b10, 3'b000, 4);
    add(2'b10, 3'b100, 4);
    add(2'b10, 3'b110, 4);
    add(2'b10, 3'b111, 4);
    add(2'b10, 3'b000, 4);
    add(2'b10, 3'b100, 4);
    add(2'b10, 3'b110, 2);
    // One-cycle brake glitch in SEQ2 restarts the sweep.
    add(2'b01, 3'b110, 1);
    add(2'b10, 3'b111, 1);
    add(2'b10, 3'b000, 4);
    add(2'b10, 3'b100, 4);
    // Brake+turn.
    add(2'b11, 3'b110, 1);
`ifdef HAZARD_EN
    add(2'b11, 3'b111, 4);
    add(2'b11, 3'b000, 4);
    add(2'b11, 3'b111, 4);
`else
    add(2'b11, 3'b111, 12);
`endif
    // Back to turn, sweep into SEQ3.
    add(2'b10, HZ_LAST, 1);
    add(2'b10, 3'b000, 4);
    add(2'b10, 3'b100, 4);
    add(2'b10, 3'b110, 4);
    add(2'b10, 3'b111, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      mode = vecs[i].mode;
      step();
      check($sformatf("vec%0d", i), vecs[i].exp_led);
    end

    // Mid-sweep reset during SEQ3: lamps go dark before the next edge.
    #2 rst_n = 1'b0;
    #1 check("midsweep_reset_async", 3'b000);
    step();
    check("midsweep_reset_held", 3'b000);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("resume_dark%0d", i), 3'b000);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("resume_seq1_%0d", i), 3'b100);
    end
    step();
    check("resume_seq2", 3'b110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
